comp4_share_ctrl: RTL and testbench
===================================

COMP4_SHARE_CTRL -- requirements
Module: comp4_share_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits.
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a, req0_b  in  WIDTH  requester 0 operands, unsigned.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- rsp_valid  out  1  result held.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester that owns the result.
- rsp_l, rsp_g, rsp_e  out  1 each  A<B, A>B, A==B.
REQ-003 There SHALL be one clock. Reset SHALL be synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, CMP and RESP.
REQ-005 IDLE: if any reqN_valid, grant one requester; reqN_ready=1 for that requester only, combinationally, in the same cycle; latch its a, b and id; go to CMP.
REQ-006 reqN_ready SHALL be 0 in CMP and RESP, and for the non-granted requester.
REQ-007 Arbitration SHALL be round-robin. With both valid, grant the requester not granted last. With one valid, grant it regardless of history.
REQ-008 CMP: the shared comparator evaluates the latched operands; register l, g and e; go to RESP.
REQ-009 RESP: rsp_valid=1. rsp_id, rsp_l, rsp_g and rsp_e SHALL stay stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-010 Exactly one of rsp_l, rsp_g, rsp_e SHALL be 1 while rsp_valid=1.
REQ-011 Latency: rsp_valid SHALL rise 2 cycles after the accept cycle. Peak throughput is 1 result per 3 cycles.
REQ-012 No new request SHALL be accepted in the cycle rsp handshakes. Acceptance resumes in the following IDLE cycle.
REQ-013 Comparison SHALL be unsigned over the full WIDTH. Boundaries: 0 vs 0 gives e; all-ones vs 0 gives g.
REQ-014 A requester that drops valid before being granted SHALL lose its turn without side effect.

Reset
REQ-015 When rst=1: state=IDLE; rsp_valid, rsp_l, rsp_g, rsp_e and rsp_id = 0; round-robin pointer = "last granted 1", so requester 0 wins the first tie.
REQ-016 Reset in CMP or RESP SHALL discard the in-flight result. rsp_valid SHALL be 0 in the cycle after rst is sampled.
REQ-017 reqN_ready SHALL be 0 during any cycle in which rst=1.

Configuration
REQ-018 Macro COMP4_SHARE_STATS_EN, when defined, SHALL add outputs grant0_cnt and grant1_cnt.
- Each is 8 bits and saturates at 255.
- Each increments on its requester's accept cycle.
- Each is cleared by rst.
REQ-019 Without COMP4_SHARE_STATS_EN, those ports and counters SHALL NOT exist. All other behaviour SHALL be identical.

Structure
REQ-020 A shared package comp4_share_pkg SHALL hold:
- the state enum: IDLE, CMP, RESP;
- the default WIDTH constant;
- the counter width constant (8).
REQ-021 The comparison SHALL be one sub-module, comp4_core: combinational, inputs a and b, outputs l, g and e. It SHALL be instantiated once and shared by both requesters.

Verification
REQ-022 req0 A=1, B=2, rsp_ready=1 -> accept cycle N, rsp_valid at N+2 with l=1, g=0, e=0, id=0.
REQ-023 req1 A=5, B=0 -> g=1, id=1. Then req1 A=0xF, B=0 -> g=1. Then req1 A=0, B=0 -> e=1.
REQ-024 req0 (1,4) and req1 (5,5) both held valid from reset -> first result id=0 with l=1, second result id=1 with e=1. No double grant.
REQ-025 req0 (3,3) with rsp_ready low for 3 cycles after rsp_valid -> rsp_valid and e=1 stay stable all 3 cycles; both readys stay 0; IDLE resumes the cycle after the handshake.
REQ-026 rst asserted in the CMP cycle of req1 (5,1) -> no rsp_valid follows. The next req1 (2,2) completes normally with e=1.
REQ-027 With COMP4_SHARE_STATS_EN defined: 300 req0 grants -> grant0_cnt=255, grant1_cnt=0.

Source files
------------

// File: rtl/comp4_share_pkg.sv
// Shared definitions for the two-requester comparator controller:
// FSM state encoding, default operand width and grant counter width.
package comp4_share_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_WIDTH     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/comp4_core.sv
// Purely combinational unsigned magnitude comparator shared by both
// requesters. Exactly one of l, g, e is high for any operand pair.
module comp4_core
    import comp4_share_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             l,
    output logic             g,
    output logic             e
);

    assign l = (a <  b);
    assign g = (a >  b);
    assign e = (a == b);

endmodule

// File: rtl/comp4_share_ctrl.sv
// Two-requester front end around a single shared comparator.
// IDLE accepts one operand pair (round-robin on ties), CMP registers the
// comparison, RESP holds the result until the consumer takes it.
// Optional build macro COMP4_SHARE_STATS_EN adds saturating per-requester
// grant counters grant0_cnt / grant1_cnt.
module comp4_share_ctrl
    import comp4_share_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_l,
    output logic             rsp_g,
    output logic             rsp_e
`ifdef COMP4_SHARE_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] grant0_cnt,
    output logic [CNT_WIDTH-1:0] grant1_cnt
`endif
);

    state_e           state;
    logic             last_grant;   // 1: requester 1 was granted most recently
    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             grant_any;
    logic             grant_id;
    logic             core_l;
    logic             core_g;
    logic             core_e;

    // Grant decision: only in IDLE outside reset; alternate on ties.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (!rst && state == IDLE) begin
            grant_any = req0_valid | req1_valid;
            if (req0_valid && req1_valid)
                grant_id = ~last_grant;
            else
                grant_id = req1_valid;
        end
    end

    assign req0_ready = grant_any & ~grant_id;
    assign req1_ready = grant_any &  grant_id;
    assign rsp_valid  = (state == RESP);
    assign rsp_id     = id_q;

    comp4_core #(.WIDTH(WIDTH)) u_core (
        .a (a_q),
        .b (b_q),
        .l (core_l),
        .g (core_g),
        .e (core_e)
    );

    // Control state, arbitration history and the registered result flags.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state.
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            rsp_l      <= 1'b0;
            rsp_g      <= 1'b0;
            rsp_e      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        state      <= CMP;
                    end
                end
                CMP: begin
                    rsp_l <= core_l;
                    rsp_g <= core_g;
                    rsp_e <= core_e;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand capture on the accept cycle.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath registers carry no reset; the FSM never reads them stale.
        if (grant_any) begin
            a_q <= grant_id ? req1_a : req0_a;
            b_q <= grant_id ? req1_b : req0_b;
        end
    end

`ifdef COMP4_SHARE_STATS_EN
    // Saturating count of accept cycles per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            if (req0_ready && grant0_cnt != '1)
                grant0_cnt <= grant0_cnt + 1'b1;
            if (req1_ready && grant1_cnt != '1)
                grant1_cnt <= grant1_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_comp4_share_ctrl.sv
// Directed self-checking bench for comp4_share_ctrl. Inputs change 1 ns
// after the rising edge, outputs are sampled on the falling edge.
module tb_comp4_share_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_l, rsp_g, rsp_e;
`ifdef COMP4_SHARE_STATS_EN
    logic [7:0] grant0_cnt, grant1_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    comp4_share_ctrl #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_l      (rsp_l),
        .rsp_g      (rsp_g),
        .rsp_e      (rsp_e)
`ifdef COMP4_SHARE_STATS_EN
        ,
        .grant0_cnt (grant0_cnt),
        .grant1_cnt (grant1_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic el, input logic eg, input logic ee);
        check({tag, ":valid"}, rsp_valid, 1'b1);
        check({tag, ":id"},    rsp_id,    id);
        check({tag, ":l"},     rsp_l,     el);
        check({tag, ":g"},     rsp_g,     eg);
        check({tag, ":e"},     rsp_e,     ee);
    endtask

    // One full transaction from IDLE with rsp_ready high. Starts and ends 1 ns after a rising edge in IDLE.
    task automatic do_req(input string tag, input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic el, input logic eg, input logic ee);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        @(negedge clk);                                   // accept cycle N
        check({tag, ":ready0"}, req0_ready, !id);
        check({tag, ":ready1"}, req1_ready, id);
        tick();                                           // N+1, CMP
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check({tag, ":cmp_valid"}, rsp_valid, 1'b0);
        tick();                                           // N+2, RESP
        @(negedge clk);
        check_rsp(tag, id, el, eg, ee);
        tick();                                           // back to IDLE
        @(negedge clk);
        check({tag, ":idle_valid"}, rsp_valid, 1'b0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd0;
        tick();
        @(negedge clk);
        check("rst:ready0", req0_ready, 1'b0);
        check("rst:ready1", req1_ready, 1'b0);
        tick();
        @(negedge clk);
        check("rst:valid", rsp_valid, 1'b0);
        check("rst:id",    rsp_id,    1'b0);
        check("rst:lge",   {rsp_l, rsp_g, rsp_e}, 3'b000);
        tick();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // Basic function and operand boundaries.
        do_req("r0_1_2",  1'b0, 4'd1,  4'd2, 1'b1, 1'b0, 1'b0);
        do_req("r1_5_0",  1'b1, 4'd5,  4'd0, 1'b0, 1'b1, 1'b0);
        do_req("r1_F_0",  1'b1, 4'hF,  4'd0, 1'b0, 1'b1, 1'b0);
        do_req("r1_0_0",  1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1);
        do_req("r0_0_F",  1'b0, 4'd0,  4'hF, 1'b1, 1'b0, 1'b0);

        // Both requesters held valid from reset: 0 first, then 1.
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd4;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("tie1:ready0", req0_ready, 1'b1);
        check("tie1:ready1", req1_ready, 1'b0);
        tick();
        @(negedge clk);
        check("tie1:cmp_ready", {req0_ready, req1_ready}, 2'b00);
        tick();
        @(negedge clk);
        check_rsp("tie1", 1'b0, 1'b1, 1'b0, 1'b0);
        check("tie1:resp_ready", {req0_ready, req1_ready}, 2'b00);
        tick();
        @(negedge clk);
        check("tie2:ready0", req0_ready, 1'b0);
        check("tie2:ready1", req1_ready, 1'b1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        @(negedge clk);
        check_rsp("tie2", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        check("tie2:idle_valid", rsp_valid, 1'b0);
        tick();

        // Back-pressure: result held 3 cycles with rsp_ready low.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd3;
        @(negedge clk);
        check("bp:accept0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_rsp("bp:hold", 1'b0, 1'b0, 1'b0, 1'b1);
            check("bp:hold_ready", {req0_ready, req1_ready}, 2'b00);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_rsp("bp:hs", 1'b0, 1'b0, 1'b0, 1'b1);
        check("bp:hs_ready", {req0_ready, req1_ready}, 2'b00);
        tick();
        @(negedge clk);
        check("bp:idle_valid", rsp_valid, 1'b0);
        check("bp:rr_ready", {req0_ready, req1_ready}, 2'b01);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        @(negedge clk);
        check_rsp("bp:next", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();

        // Reset during CMP discards the in-flight result.
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd1;
        @(negedge clk);
        check("rstcmp:accept1", req1_ready, 1'b1);
        tick();
        rst = 1'b1; req1_valid = 1'b0; req0_valid = 1'b1;
        @(negedge clk);
        check("rstcmp:ready0", req0_ready, 1'b0);
        tick();
        rst = 1'b0; req0_valid = 1'b0;
        @(negedge clk);
        check("rstcmp:valid0", rsp_valid, 1'b0);
        tick();
        @(negedge clk);
        check("rstcmp:valid1", rsp_valid, 1'b0);
        tick();
        do_req("rstcmp:next", 1'b1, 4'd2, 4'd2, 1'b0, 1'b0, 1'b1);

`ifdef COMP4_SHARE_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("stats:clr0", grant0_cnt, 8'd0);
        check("stats:clr1", grant1_cnt, 8'd0);
        tick();
        for (int i = 0; i < 300; i++)
            do_req("stats:req", 1'b0, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("stats:cnt0", grant0_cnt, 8'd255);
        check("stats:cnt1", grant1_cnt, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
